// File: rtl/detect_event_logger.sv
// Timestamps rising edges of the 1101 detector flag into a small FWFT FIFO,
// with a saturating event counter and a sticky overflow flag for debug readout.
module detect_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     det_in,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [TS_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         event_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [TS_W-1:0]  ts_q;
    logic             det_prev_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [TS_W-1:0]  mem_q [DEPTH];

    logic ev, pop, push, full;

    always_comb begin
        ev      = det_in & ~det_prev_q;
        pop     = (level_q != '0) & rd_ready;
        full    = (level_q == LW'(DEPTH));
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push    = ev & (~full | pop);
        level_d = level_q;
        if (push & ~pop)
            level_d = level_q + 1'b1;
        else if (pop & ~push)
            level_d = level_q - 1'b1;
        cnt_d = cnt_q;
        if (ev && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
        ovf_d = ovf_q | (ev & ~push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            det_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            ts_q       <= ts_q + 1'b1;
            det_prev_q <= det_in;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            if (push) begin
                mem_q[wr_ptr_q] <= ts_q;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rd_valid    = (level_q != '0);
    assign rd_data     = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign event_count = cnt_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_detect_event_logger.sv
// Randomized and directed bench for detect_event_logger; two instances
// (16/8-bit and 4/3-bit timestamp/counter) share stimulus and one queue model.
module tb_detect_event_logger;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic det_in = 1'b0;
    logic rd_ready = 1'b0;
    bit   run = 1'b0;

    logic        rd_valid_a, ovf_a;
    logic [15:0] rd_data_a;
    logic [3:0]  level_a;
    logic [7:0]  cnt_a;

    logic        rd_valid_b, ovf_b;
    logic [3:0]  rd_data_b;
    logic [3:0]  level_b;
    logic [2:0]  cnt_b;

    int total = 0;
    int bad = 0;

    detect_event_logger #(.TS_W(16), .DEPTH(8), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .det_in(det_in), .rd_ready(rd_ready),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .level(level_a),
        .event_count(cnt_a), .overflow(ovf_a)
    );

    detect_event_logger #(.TS_W(4), .DEPTH(8), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .det_in(det_in), .rd_ready(rd_ready),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .level(level_b),
        .event_count(cnt_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queue of edge numbers since reset (the timestamp is just that number
    // modulo 2^TS_W), plus a plain count of rising edges of det_in.
    int mq[$];
    int cyc = 0;
    int nev = 0;
    bit prev = 0;
    bit movf = 0;

    always @(posedge clk or posedge reset) begin
        bit ev, pop;
        if (reset) begin
            mq.delete();
            cyc  = 0;
            nev  = 0;
            prev = 0;
            movf = 0;
        end else begin
            ev  = det_in && !prev;
            pop = (mq.size() != 0) && rd_ready;
            if (pop) void'(mq.pop_front());
            if (ev) begin
                nev++;
                if (mq.size() < 8) mq.push_back(cyc);
                else movf = 1;
            end
            prev = det_in;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("level_a", 32'(level_a), 32'(mq.size()));
            chk("level_b", 32'(level_b), 32'(mq.size()));
            chk("valid_a", 32'(rd_valid_a), 32'(mq.size() != 0));
            chk("valid_b", 32'(rd_valid_b), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("data_a", 32'(rd_data_a), 32'(mq[0] % 65536));
                chk("data_b", 32'(rd_data_b), 32'(mq[0] % 16));
            end
            chk("count_a", 32'(cnt_a), 32'((nev > 255) ? 255 : nev));
            chk("count_b", 32'(cnt_b), 32'((nev > 7) ? 7 : nev));
            chk("ovf_a", 32'(ovf_a), 32'(movf));
            chk("ovf_b", 32'(ovf_b), 32'(movf));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset between edges, check the async clear, release on next negedge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_level", 32'(level_a), 32'd0);
        chk("rst_valid", 32'(rd_valid_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_ovf", 32'(ovf_a), 32'd0);
        chk("rst_data", 32'(rd_data_a), 32'd0);
        chk("rst_count_b", 32'(cnt_b), 32'd0);
        det_in   = 1'b0;
        rd_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse(input int gap);
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;

        // single pulse sampled at edge 6 (ts=5)
        repeat (5) tick();
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        chk("single_valid", 32'(rd_valid_a), 32'd1);
        chk("single_data", 32'(rd_data_a), 32'd5);
        chk("single_level", 32'(level_a), 32'd1);
        chk("single_count", 32'(cnt_a), 32'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("single_drain_level", 32'(level_a), 32'd0);
        chk("single_drain_valid", 32'(rd_valid_a), 32'd0);

        // held high 4 edges, low 1, high 1: events at edges 8 and 13
        det_in = 1'b1;
        repeat (4) tick();
        det_in = 1'b0;
        tick();
        det_in = 1'b1;
        tick();
        det_in = 1'b0;
        chk("held_level", 32'(level_a), 32'd2);
        chk("held_count", 32'(cnt_a), 32'd3);
        chk("held_first", 32'(rd_data_a), 32'd7);
        rd_ready = 1'b1;
        tick();
        chk("held_second", 32'(rd_data_a), 32'd12);
        tick();
        rd_ready = 1'b0;
        chk("held_empty", 32'(rd_valid_a), 32'd0);

        // overflow: 9 pulses into 8 slots, timestamps 0,2,..,14 kept
        do_reset();
        repeat (9) pulse(1);
        chk("ovf_level", 32'(level_a), 32'd8);
        chk("ovf_flag", 32'(ovf_a), 32'd1);
        chk("ovf_count", 32'(cnt_a), 32'd9);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", 32'(rd_data_a), 32'(2 * i));
            tick();
        end
        rd_ready = 1'b0;
        chk("ovf_drained", 32'(rd_valid_a), 32'd0);
        chk("ovf_sticky", 32'(ovf_a), 32'd1);

        // full push+pop on the same edge (edge 17, ts=16)
        do_reset();
        repeat (8) pulse(1);
        chk("full_level", 32'(level_a), 32'd8);
        det_in   = 1'b1;
        rd_ready = 1'b1;
        tick();
        det_in = 1'b0;
        chk("fpp_level", 32'(level_a), 32'd8);
        chk("fpp_ovf", 32'(ovf_a), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("fpp_drain", 32'(rd_data_a), 32'(2 * i + 2));
            tick();
        end
        rd_ready = 1'b0;
        chk("fpp_empty", 32'(rd_valid_a), 32'd0);

        // wrap/saturation: pulse every 3 edges while draining
        do_reset();
        rd_ready = 1'b1;
        repeat (14) pulse(2);
        chk("wrap_count_b", 32'(cnt_b), 32'd7);
        chk("wrap_count_a", 32'(cnt_a), 32'd14);
        chk("wrap_ovf_b", 32'(ovf_b), 32'd0);

        // random traffic with alternating drain rates and occasional resets
        for (int i = 0; i < 3000; i++) begin
            det_in   = ($urandom_range(0, 2) == 0);
            rd_ready = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else tick();
        end

        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
